// File: rtl/inst_queue_sequencer_if.sv
// Prefetch-side and scheduler-side signals of the instruction queue sequencer.
// The slave modport is the sequencer; the master modport drives it.
interface inst_queue_sequencer_if #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned MAX_STAGES = 2
) ();
    localparam int unsigned SB = $clog2(MAX_STAGES);
    localparam int unsigned CB = $clog2(DEPTH + 1);

    logic          in_valid;
    logic [15:0]   in_inst;
    logic          in_ready;
    logic          flush;
    logic          uop_valid;
    logic [15:0]   uop_inst;
    logic [SB-1:0] uop_stage;
    logic          uop_pre;
    logic          uop_last;
    logic          uop_done;
    logic          inst_retired;
    logic [CB-1:0] queue_count;

    modport master (
        output in_valid, in_inst, flush, uop_done,
        input  in_ready, uop_valid, uop_inst, uop_stage, uop_pre, uop_last,
               inst_retired, queue_count
    );

    modport slave (
        input  in_valid, in_inst, flush, uop_done,
        output in_ready, uop_valid, uop_inst, uop_stage, uop_pre, uop_last,
               inst_retired, queue_count
    );
endinterface

// File: rtl/inst_queue_sequencer.sv
// Circular instruction FIFO that presents its head once per stage; call-type
// instructions get an extra push-pc pre-stage. Flush drops everything queued.
module inst_queue_sequencer #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned MAX_STAGES   = 2,
    parameter logic [3:0]  CC_CALL_CODE = 4'hf,
    parameter bit          CALL_SRC_EN  = 1'b1
) (
    input logic                    clk,
    input logic                    reset,
    inst_queue_sequencer_if.slave  bus
);
    localparam int unsigned SB = $clog2(MAX_STAGES);
    localparam int unsigned CB = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [15:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CB-1:0] count_q, count_d;
    logic [SB-1:0] stage_q, stage_d;

    logic [15:0] head;
    logic        is_call;
    logic        last;
    logic        in_ready;
    logic        uop_valid;
    logic        push;
    logic        retire;
    logic        advance;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        head    = mem_q[rd_ptr_q];
        is_call = ((head[15:12] == 4'h0) && (head[11:8] == CC_CALL_CODE)) ||
                  (CALL_SRC_EN && (head[15:6] == 10'b0010000001));
        last    = is_call ? (stage_q == SB'(1)) : (stage_q == '0);

        // Ready looks only at registered occupancy, so a same-cycle pop never raises it.
        in_ready  = !reset && !bus.flush && (count_q < CB'(DEPTH));
        uop_valid = !reset && !bus.flush && (count_q != '0);
        push      = bus.in_valid && in_ready;
        retire    = uop_valid && bus.uop_done && last;
        advance   = uop_valid && bus.uop_done && !last;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        stage_d  = stage_q;
        if (bus.flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
            stage_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (retire) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                stage_d  = '0;
            end else if (advance) begin
                stage_d = stage_q + SB'(1);
            end
            if (push && !retire) begin
                count_d = count_q + CB'(1);
            end else if (retire && !push) begin
                count_d = count_q - CB'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stage_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stage_q  <= stage_d;
        end
    end

    // Storage needs no reset; push is already blocked during reset and flush.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_inst;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.uop_valid    = uop_valid;
    assign bus.uop_inst     = head;
    assign bus.uop_stage    = stage_q;
    assign bus.uop_pre      = is_call && (stage_q == '0);
    assign bus.uop_last     = last;
    assign bus.inst_retired = retire;
    assign bus.queue_count  = count_q;
endmodule

// File: tb/tb_inst_queue_sequencer.sv
// Directed bench: a vector table on a DEPTH=2 instance, then hand sequences for
// mid-operation reset, throughput on DEPTH=3 and CALL_SRC_EN=0 decoding.
module tb_inst_queue_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    inst_queue_sequencer_if #(.DEPTH(2), .MAX_STAGES(2)) ia ();
    inst_queue_sequencer_if #(.DEPTH(3), .MAX_STAGES(2)) ib ();

    inst_queue_sequencer #(
        .DEPTH(2), .MAX_STAGES(2), .CC_CALL_CODE(4'hf), .CALL_SRC_EN(1'b1)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ia.slave)
    );

    inst_queue_sequencer #(
        .DEPTH(3), .MAX_STAGES(2), .CC_CALL_CODE(4'hf), .CALL_SRC_EN(1'b0)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ib.slave)
    );

    typedef struct {
        logic        iv;
        logic [15:0] inst;
        logic        fl;
        logic        dn;
        logic        uv;
        logic [15:0] ui;
        logic        st;
        logic        pre;
        logic        last;
        logic        ret;
        logic        rdy;
        logic [1:0]  cnt;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [15:0] inst, input logic fl,
                                input logic dn, input logic uv, input logic [15:0] ui,
                                input logic st, input logic pre, input logic last,
                                input logic ret, input logic rdy, input logic [1:0] cnt);
        vec_t v;
        v.iv = iv; v.inst = inst; v.fl = fl; v.dn = dn;
        v.uv = uv; v.ui = ui; v.st = st; v.pre = pre; v.last = last;
        v.ret = ret; v.rdy = rdy; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic iv, input logic [15:0] inst, input logic fl,
                           input logic dn);
        ia.in_valid = iv;
        ia.in_inst  = inst;
        ia.flush    = fl;
        ia.uop_done = dn;
    endtask

    task automatic drive_b(input logic iv, input logic [15:0] inst, input logic dn);
        ib.in_valid = iv;
        ib.in_inst  = inst;
        ib.flush    = 1'b0;
        ib.uop_done = dn;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vt[$];

    initial begin
        int rcount;
        int seen;
        logic [15:0] expw;
        reset = 1'b1;
        drive_a(1'b1, 16'h5555, 1'b0, 1'b1);
        drive_b(1'b0, 16'h0, 1'b0);

        // Reset phase: outputs forced low regardless of inputs.
        step();
        @(negedge clk);
        chk("rst_uop_valid", 32'(ia.uop_valid), 32'd0);
        chk("rst_in_ready", 32'(ia.in_ready), 32'd0);
        chk("rst_retired", 32'(ia.inst_retired), 32'd0);
        step();
        reset = 1'b0;
        drive_a(1'b0, 16'h0, 1'b0, 1'b0);

        //         iv    inst      fl    dn    uv    ui        st    pre   last  ret   rdy   cnt
        vt.push_back(mk(1'b1, 16'h8A05, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
        vt.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h8A05, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1));
        vt.push_back(mk(1'b1, 16'h0F12, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
        vt.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0F12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1));
        vt.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0F12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1));
        vt.push_back(mk(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
        vt.push_back(mk(1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1));
        vt.push_back(mk(1'b1, 16'h3333, 1'b0, 1'b0, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2));
        vt.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2));
        vt.push_back(mk(1'b1, 16'h3333, 1'b0, 1'b0, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1));
        vt.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2));
        vt.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h3333, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1));
        vt.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
        vt.push_back(mk(1'b1, 16'h2041, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
        vt.push_back(mk(1'b1, 16'h9000, 1'b0, 1'b1, 1'b1, 16'h2041, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1));
        vt.push_back(mk(1'b1, 16'h7777, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2));
        vt.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
        vt.push_back(mk(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
        vt.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1));
        vt.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0));

        foreach (vt[i]) begin
            drive_a(vt[i].iv, vt[i].inst, vt[i].fl, vt[i].dn);
            @(negedge clk);
            chk($sformatf("v%0d_uop_valid", i), 32'(ia.uop_valid), 32'(vt[i].uv));
            chk($sformatf("v%0d_retired", i), 32'(ia.inst_retired), 32'(vt[i].ret));
            chk($sformatf("v%0d_in_ready", i), 32'(ia.in_ready), 32'(vt[i].rdy));
            chk($sformatf("v%0d_count", i), 32'(ia.queue_count), 32'(vt[i].cnt));
            if (vt[i].uv) begin
                chk($sformatf("v%0d_inst", i), 32'(ia.uop_inst), 32'(vt[i].ui));
                chk($sformatf("v%0d_stage", i), 32'(ia.uop_stage), 32'(vt[i].st));
                chk($sformatf("v%0d_pre", i), 32'(ia.uop_pre), 32'(vt[i].pre));
                chk($sformatf("v%0d_last", i), 32'(ia.uop_last), 32'(vt[i].last));
            end
            step();
        end

        // Reset while a call sits at stage 1: it is dropped with no retire.
        drive_a(1'b1, 16'h0F12, 1'b0, 1'b0);
        step();
        drive_a(1'b0, 16'h0, 1'b0, 1'b1);
        step();
        drive_a(1'b0, 16'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("mid_stage1", 32'(ia.uop_stage), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(ia.uop_valid), 32'd0);
        chk("mid_rst_retired", 32'(ia.inst_retired), 32'd0);
        chk("mid_rst_ready", 32'(ia.in_ready), 32'd0);
        step();
        reset = 1'b0;
        drive_a(1'b0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_rst_count", 32'(ia.queue_count), 32'd0);
        chk("post_rst_stage", 32'(ia.uop_stage), 32'd0);
        chk("post_rst_ready", 32'(ia.in_ready), 32'd1);
        step();

        // DEPTH=3 streaming: one push and one retire per cycle once primed.
        rcount = 0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (c < 10) drive_b(1'b1, 16'hA000 + 16'(c), 1'b1);
            else        drive_b(1'b0, 16'h0, 1'b1);
            @(negedge clk);
            if (c < 10) chk($sformatf("tp%0d_ready", c), 32'(ib.in_ready), 32'd1);
            if (ib.queue_count > 2'd1) chk($sformatf("tp%0d_count", c), 32'(ib.queue_count), 32'd1);
            if (c >= 1 && c <= 10) begin
                chk($sformatf("tp%0d_retired", c), 32'(ib.inst_retired), 32'd1);
            end
            if (ib.inst_retired) begin
                expw = 16'hA000 + 16'(rcount);
                chk($sformatf("tp%0d_order", c), 32'(ib.uop_inst), 32'(expw));
                rcount++;
            end
            seen = c;
            step();
            if (rcount == 10 && c >= 11) break;
        end
        chk("tp_total", 32'(rcount), 32'd10);
        chk("tp_cycles", 32'(seen), 32'd11);

        // CALL_SRC_EN=0: call-src encoding is a plain one-stage instruction.
        drive_b(1'b1, 16'h2041, 1'b0);
        step();
        drive_b(1'b0, 16'h0, 1'b1);
        @(negedge clk);
        chk("src_valid", 32'(ib.uop_valid), 32'd1);
        chk("src_inst", 32'(ib.uop_inst), 32'h2041);
        chk("src_stage", 32'(ib.uop_stage), 32'd0);
        chk("src_last", 32'(ib.uop_last), 32'd1);
        chk("src_pre", 32'(ib.uop_pre), 32'd0);
        chk("src_retired", 32'(ib.inst_retired), 32'd1);
        step();
        drive_b(1'b0, 16'h0, 1'b1);
        @(negedge clk);
        chk("empty_valid", 32'(ib.uop_valid), 32'd0);
        chk("empty_retired", 32'(ib.inst_retired), 32'd0);
        step();
        drive_b(1'b0, 16'h0, 1'b0);
        @(negedge clk);
        chk("empty_count", 32'(ib.queue_count), 32'd0);
        chk("empty_stage", 32'(ib.uop_stage), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
